// File: rtl/fios_res_pkg.sv
// Shared types for the FIOS result collector: word width, word type and FSM states.
package fios_res_pkg;

    localparam int WORD_W = 17;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SUB     = 2'd2,
        OUT     = 2'd3
    } state_t;

endpackage

// File: rtl/fios_word_sub.sv
// Single 17-bit subtract-with-borrow slice (d = a - b - bin); only built with FIOS_RES_FINAL_SUB_EN.
`ifdef FIOS_RES_FINAL_SUB_EN
module fios_word_sub
    import fios_res_pkg::*;
(
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic              bin_i,
    output logic [WORD_W-1:0] d_o,
    output logic              bout_o
);

    logic [WORD_W:0] diff_s;

    // One extra bit on the left catches the borrow out of the word.
    assign diff_s = {1'b0, a_i} - {1'b0, b_i} - {{WORD_W{1'b0}}, bin_i};
    assign d_o    = diff_s[WORD_W-1:0];
    assign bout_o = diff_s[WORD_W];

endmodule
`endif

// File: rtl/fios_res_collector.sv
// Captures the multiplier's result words and streams them out LSW first over valid/ready.
// Macro FIOS_RES_FINAL_SUB_EN adds the serial final conditional subtraction of p.
module fios_res_collector
    import fios_res_pkg::*;
#(
    parameter int s = 8
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              p_load_i,
    input  logic [WORD_W-1:0] p_word_i,
    input  logic              RES_push_i,
    input  logic [WORD_W-1:0] RES_i,
    input  logic              done_i,
    output logic              res_valid_o,
    output logic [WORD_W-1:0] res_word_o,
    output logic              res_last_o,
    input  logic              res_ready_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int PW = $clog2(s + 1);
    localparam int IW = (s > 1) ? $clog2(s) : 1;
    localparam logic [PW-1:0] S_CNT    = PW'(s);
    localparam logic [IW-1:0] LAST_IDX = IW'(s - 1);
`ifdef FIOS_RES_FINAL_SUB_EN
    localparam state_t AFTER_COLLECT = SUB;
`else
    localparam state_t AFTER_COLLECT = OUT;
`endif

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [IW-1:0] rd_ptr_q, rd_ptr_d;
    logic          busy_q;
    logic          err_q;
    word_t         res_mem [s];

    logic          push_ok_s;
    logic          done_go_s;
    logic [PW-1:0] cnt_at_done_s;
    logic          err_set_s;
    word_t         rd_word_s;

`ifdef FIOS_RES_FINAL_SUB_EN
    word_t         p_mem    [s];
    word_t         diff_mem [s];
    logic [IW-1:0] p_ptr_q, p_ptr_d;
    logic [IW-1:0] k_q, k_d;
    logic          borrow_q, borrow_d;
    logic          select_q, select_d;
    logic          p_we_s;
    logic          diff_we_s;
    word_t         sub_d_s;
    logic          sub_bout_s;
`else
    logic          unused_p_s;
    assign unused_p_s = ^{p_load_i, p_word_i};
`endif

    // Pushes are accepted in IDLE (into word 0) and in COLLECT while there is room.
    assign push_ok_s     = RES_push_i && ((state_q == IDLE) ||
                           ((state_q == COLLECT) && (wr_ptr_q != S_CNT)));
    assign done_go_s     = done_i && ((state_q == COLLECT) ||
                           ((state_q == IDLE) && RES_push_i));
    assign cnt_at_done_s = wr_ptr_q + (push_ok_s ? PW'(1) : PW'(0));
    assign err_set_s     = (RES_push_i && !push_ok_s) ||
                           (done_i && !done_go_s) ||
                           (done_go_s && (cnt_at_done_s != S_CNT));

`ifdef FIOS_RES_FINAL_SUB_EN
    assign p_we_s = p_load_i && (state_q == IDLE) && !RES_push_i;

    fios_word_sub u_word_sub (
        .a_i    (res_mem[k_q]),
        .b_i    (p_mem[k_q]),
        .bin_i  (borrow_q),
        .d_o    (sub_d_s),
        .bout_o (sub_bout_s)
    );
`endif

    // Next-state and pointer logic.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = push_ok_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
`ifdef FIOS_RES_FINAL_SUB_EN
        k_d       = k_q;
        borrow_d  = borrow_q;
        select_d  = select_q;
        diff_we_s = 1'b0;
        p_ptr_d   = p_ptr_q;
        if (p_we_s) begin
            p_ptr_d = (p_ptr_q == LAST_IDX) ? IW'(0) : (p_ptr_q + IW'(1));
        end else begin
            p_ptr_d = p_ptr_q;
        end
`endif
        case (state_q)
            IDLE: begin
                if (done_go_s) begin
                    state_d = AFTER_COLLECT;
                end else if (RES_push_i) begin
                    state_d = COLLECT;
                end else begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                if (done_i) begin
                    state_d = AFTER_COLLECT;
                end else begin
                    state_d = COLLECT;
                end
            end
`ifdef FIOS_RES_FINAL_SUB_EN
            SUB: begin
                diff_we_s = 1'b1;
                borrow_d  = sub_bout_s;
                if (k_q == LAST_IDX) begin
                    select_d = ~sub_bout_s;
                    k_d      = IW'(0);
                    state_d  = OUT;
                end else begin
                    k_d      = k_q + IW'(1);
                    state_d  = SUB;
                end
            end
`endif
            OUT: begin
                if (res_ready_i && (rd_ptr_q == LAST_IDX)) begin
                    state_d  = IDLE;
                    rd_ptr_d = IW'(0);
                    wr_ptr_d = PW'(0);
`ifdef FIOS_RES_FINAL_SUB_EN
                    borrow_d = 1'b0;
`endif
                end else if (res_ready_i) begin
                    rd_ptr_d = rd_ptr_q + IW'(1);
                end else begin
                    rd_ptr_d = rd_ptr_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers with synchronous reset; busy tracks the state being entered.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= IW'(0);
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            busy_q   <= (state_d != IDLE);
            err_q    <= err_q | err_set_s;
        end
    end

    // Storage arrays are deliberately not reset.
    always_ff @(posedge clock_i) begin
        if (!reset_i && push_ok_s) begin
            res_mem[wr_ptr_q[IW-1:0]] <= RES_i;
        end
`ifdef FIOS_RES_FINAL_SUB_EN
        if (!reset_i && p_we_s) begin
            p_mem[p_ptr_q] <= p_word_i;
        end
        if (!reset_i && diff_we_s) begin
            diff_mem[k_q] <= sub_d_s;
        end
`endif
    end

`ifdef FIOS_RES_FINAL_SUB_EN
    // Subtraction sequencing registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            p_ptr_q  <= IW'(0);
            k_q      <= IW'(0);
            borrow_q <= 1'b0;
            select_q <= 1'b0;
        end else begin
            p_ptr_q  <= p_ptr_d;
            k_q      <= k_d;
            borrow_q <= borrow_d;
            select_q <= select_d;
        end
    end

    assign rd_word_s = select_q ? diff_mem[rd_ptr_q] : res_mem[rd_ptr_q];
`else
    assign rd_word_s = res_mem[rd_ptr_q];
`endif

    assign res_valid_o = (state_q == OUT);
    assign res_last_o  = res_valid_o && (rd_ptr_q == LAST_IDX);
    assign res_word_o  = res_valid_o ? rd_word_s : '0;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_fios_res_collector.sv
// Self-checking bench for fios_res_collector with s=2: directed cases plus random p/RES pairs.
module tb_fios_res_collector;

    localparam int S = 2;
`ifdef FIOS_RES_FINAL_SUB_EN
    localparam int FIRST_LAT = S + 1;
`else
    localparam int FIRST_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p_load = 1'b0;
    logic [16:0] p_word = 17'd0;
    logic        push = 1'b0;
    logic [16:0] res_in = 17'd0;
    logic        done = 1'b0;
    logic        valid;
    logic [16:0] word;
    logic        last;
    logic        ready = 1'b0;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [16:0] model_p   [S];
    logic [16:0] model_res [S];
    logic [16:0] stim      [4];
    bit          err_exp;

    fios_res_collector #(.s(S)) dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .p_load_i    (p_load),
        .p_word_i    (p_word),
        .RES_push_i  (push),
        .RES_i       (res_in),
        .done_i      (done),
        .res_valid_o (valid),
        .res_word_o  (word),
        .res_last_o  (last),
        .res_ready_i (ready),
        .busy_o      (busy),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: 34-bit value of the captured words, reduced by p once when enabled.
    function automatic logic [33:0] expected_value();
        logic [33:0] r;
        logic [33:0] p;
        r = {model_res[1], model_res[0]};
        p = {model_p[1], model_p[0]};
`ifdef FIOS_RES_FINAL_SUB_EN
        if (r >= p) r = r - p;
`endif
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1; p_load = 1'b0; push = 1'b0; done = 1'b0; ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        err_exp = 1'b0;
        check("reset_busy",  {33'd0, busy},  34'd0);
        check("reset_valid", {33'd0, valid}, 34'd0);
        check("reset_word",  {17'd0, word},  34'd0);
        check("reset_last",  {33'd0, last},  34'd0);
        check("reset_err",   {33'd0, err},   34'd0);
    endtask

    task automatic load_p(input logic [16:0] w0, input logic [16:0] w1);
        p_load = 1'b1; p_word = w0; tick(); model_p[0] = w0;
        p_word = w1;               tick(); model_p[1] = w1;
        p_load = 1'b0;
    endtask

    task automatic run_op(input string name, input int npush, input int stall, input bit push_in_out);
        logic [33:0] exp;
        logic [16:0] exp_w [S];
        int lat;
        for (int i = 0; i < npush; i++) begin
            push = 1'b1; res_in = stim[i];
            tick();
            if (i < S) model_res[i] = stim[i];
        end
        push = 1'b0;
        if (npush != S) err_exp = 1'b1;
        done = 1'b1;
        tick();
        done = 1'b0;
        lat = 1;
        check({name, "_busy"}, {33'd0, busy}, 34'd1);
        while (!valid && lat < 40) begin
            tick();
            lat++;
        end
        check({name, "_lat"}, 34'(lat), 34'(FIRST_LAT));
        if (!valid) return;
        exp = expected_value();
        exp_w[0] = exp[16:0];
        exp_w[1] = exp[33:17];
        if (stall > 0) begin
            ready = 1'b0;
            for (int c = 0; c < stall; c++) begin
                check({name, "_hold_word"},  {17'd0, word},  {17'd0, exp_w[0]});
                check({name, "_hold_valid"}, {33'd0, valid}, 34'd1);
                push = push_in_out && (c == 1);
                res_in = 17'(~exp_w[0]);
                tick();
            end
            push = 1'b0;
            if (push_in_out) err_exp = 1'b1;
        end
        ready = 1'b1;
        for (int j = 0; j < S; j++) begin
            check({name, "_word"}, {17'd0, word}, {17'd0, exp_w[j]});
            check({name, "_last"}, {33'd0, last}, {33'd0, (j == S - 1)});
            tick();
        end
        ready = 1'b0;
        check({name, "_idle_busy"},  {33'd0, busy},  34'd0);
        check({name, "_idle_valid"}, {33'd0, valid}, 34'd0);
        check({name, "_err"},        {33'd0, err},   {33'd0, err_exp});
    endtask

    initial begin
        logic [63:0] pv;
        logic [63:0] lim;
        logic [63:0] rv;
        err_exp = 1'b0;
        do_reset();

        load_p(17'h00005, 17'h00000);
        stim[0] = 17'h00007; stim[1] = 17'h00000; run_op("sub7", 2, 0, 1'b0);
        stim[0] = 17'h00003; stim[1] = 17'h00000; run_op("keep3", 2, 0, 1'b0);
        stim[0] = 17'h00005; stim[1] = 17'h00000; run_op("eq5", 2, 0, 1'b0);

        load_p(17'h1FFFF, 17'h00001);
        stim[0] = 17'h00000; stim[1] = 17'h00003; run_op("borrow", 2, 0, 1'b0);
        stim[0] = 17'h0ABCD; stim[1] = 17'h00002; run_op("stall", 2, 5, 1'b1);
        tick();
        check("stall_err_sticky", {33'd0, err}, 34'd1);

        do_reset();
        stim[0] = 17'h01234; run_op("short", 1, 0, 1'b0);
        do_reset();
        stim[0] = 17'h00011; stim[1] = 17'h00001; stim[2] = 17'h1FFFF;
        run_op("long", 3, 0, 1'b0);

        do_reset();
        push = 1'b1; res_in = 17'h00001; tick();
        res_in = 17'h00002; tick();
        push = 1'b0; done = 1'b1; tick();
        done = 1'b0; tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        check("rst_mid_busy",  {33'd0, busy},  34'd0);
        check("rst_mid_valid", {33'd0, valid}, 34'd0);
        check("rst_mid_err",   {33'd0, err},   34'd0);
        err_exp = 1'b0;

        for (int n = 0; n < 24; n++) begin
            pv = {$urandom, $urandom} & 64'h3_FFFF_FFFF;
            if (pv == 64'd0) pv = 64'd1;
            lim = 64'd2 * pv;
            if (lim > 64'h4_0000_0000) lim = 64'h4_0000_0000;
            case ($urandom_range(0, 3))
                0:       rv = pv;
                1:       rv = pv - 64'd1;
                default: rv = {$urandom, $urandom} % lim;
            endcase
            load_p(pv[16:0], pv[33:17]);
            stim[0] = rv[16:0]; stim[1] = rv[33:17];
            run_op("rand", 2, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
